// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the digital-clock mode controller.
// Mode encodings, counter limits and counter port widths.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_MIN = 2'd1,
    MODE_SET_HR  = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam logic [SEC_W-1:0] SEC_LAST = 6'd59;
  localparam logic [MIN_W-1:0] MIN_LAST = 6'd59;
  localparam logic [HR_W-1:0]  HR_LAST  = 5'd23;

  // The reserved encoding advances as if it were RUN.
  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    case (m)
      MODE_RUN:     n = MODE_SET_MIN;
      MODE_SET_MIN: n = MODE_SET_HR;
      MODE_SET_HR:  n = MODE_RUN;
      default:      n = MODE_SET_MIN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/clock_mode_controller_counter.sv
// Generic wrapping counter: counts 0..MAX_NUMBER-1 on each enable.
// Used as the sub-second divider of the clock controller.
module clock_mode_controller_counter #(
  parameter int WIDTH      = 2,
  parameter int MAX_NUMBER = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_NUMBER - 1);

  logic [WIDTH-1:0] r_count;

  // Count register, wraps after LAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_en) begin
      if (r_count == LAST) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + WIDTH'(1);
      end
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/clock_mode_controller.sv
// Mode / carry controller for the seconds-minutes-hours counter chain:
// RUN / SET_MIN / SET_HR machine, cascade carries, set timeout and blink.
module clock_mode_controller
  import clock_ctrl_pkg::*;
#(
  parameter int SUBTICKS  = 4,
  parameter int TIMEOUT_S = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             btn_mode,
  input  logic             btn_up,
  input  logic [SEC_W-1:0] sec,
  input  logic [MIN_W-1:0] min,
  input  logic [HR_W-1:0]  hr,
  output logic             en_sec,
  output logic             en_min,
  output logic             en_hr,
  output logic [1:0]       mode,
  output logic             blank_min,
  output logic             blank_hr
);

  localparam int SUB_W  = (SUBTICKS > 1) ? $clog2(SUBTICKS) : 1;
  localparam int IDLE_W = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SUBTICKS - 1);
  localparam logic [SUB_W-1:0]  SUB_HALF  = SUB_W'(SUBTICKS / 2);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S - 1);

  logic [SUB_W-1:0]  w_sub;
  mode_e             r_mode;
  mode_e             w_mode_nxt;
  logic [IDLE_W-1:0] r_idle;
  logic [IDLE_W-1:0] w_idle_nxt;
  logic              w_sec_evt;
  logic              w_in_set;
  logic              w_unused;

  clock_mode_controller_counter #(
    .WIDTH      (SUB_W),
    .MAX_NUMBER (SUBTICKS)
  ) u_sub_div (
    .clk     (clk),
    .reset   (reset),
    .i_en    (tick),
    .o_count (w_sub)
  );

  assign w_sec_evt = tick && (w_sub == SUB_LAST);
  assign w_in_set  = (r_mode == MODE_SET_MIN) || (r_mode == MODE_SET_HR);
  // Hours wrap inside the external counter, so hr never feeds a carry.
  assign w_unused  = ^hr;
  assign mode      = r_mode;

  // Mode and idle-second state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= MODE_RUN;
      r_idle <= '0;
    end else begin
      r_mode <= w_mode_nxt;
      r_idle <= w_idle_nxt;
    end
  end

  // Enables, blink and next-state; everything resolves against the current mode.
  always_comb begin
    w_mode_nxt = r_mode;
    w_idle_nxt = r_idle;
    en_sec     = 1'b0;
    en_min     = 1'b0;
    en_hr      = 1'b0;
    blank_min  = 1'b0;
    blank_hr   = 1'b0;

    case (r_mode)
      MODE_SET_MIN: begin
        en_min    = btn_up;
        blank_min = (w_sub >= SUB_HALF);
      end
      MODE_SET_HR: begin
        en_hr    = btn_up;
        blank_hr = (w_sub >= SUB_HALF);
      end
      default: begin
        en_sec = w_sec_evt;
        en_min = w_sec_evt && (sec == SEC_LAST);
        en_hr  = w_sec_evt && (sec == SEC_LAST) && (min == MIN_LAST);
      end
    endcase

    if (btn_mode) begin
      w_mode_nxt = next_mode(r_mode);
      w_idle_nxt = '0;
    end else if (w_in_set) begin
      if (btn_up) begin
        w_idle_nxt = '0;
      end else if (w_sec_evt) begin
        if (r_idle == IDLE_LAST) begin
          w_mode_nxt = MODE_RUN;
          w_idle_nxt = '0;
        end else begin
          w_idle_nxt = r_idle + IDLE_W'(1);
        end
      end else begin
        w_idle_nxt = r_idle;
      end
    end else begin
      w_mode_nxt = MODE_RUN;
      w_idle_nxt = '0;
    end
  end

endmodule

// File: tb/tb_clock_mode_controller.sv
// Self-checking bench for clock_mode_controller: vector table, corner
// sequences and a randomized run against a time-of-day reference model.
module tb_clock_mode_controller;

  localparam int SUBTICKS  = 4;
  localparam int TIMEOUT_S = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic [5:0] sec = 6'd0;
  logic [5:0] min = 6'd0;
  logic [4:0] hr = 5'd0;
  logic       en_sec, en_min, en_hr, blank_min, blank_hr;
  logic [1:0] mode;

  int n_tests = 0;
  int n_fail  = 0;

  clock_mode_controller #(.SUBTICKS(SUBTICKS), .TIMEOUT_S(TIMEOUT_S)) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_mode(btn_mode), .btn_up(btn_up),
    .sec(sec), .min(min), .hr(hr), .en_sec(en_sec), .en_min(en_min), .en_hr(en_hr),
    .mode(mode), .blank_min(blank_min), .blank_hr(blank_hr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       t, bm, bu;
    logic [5:0] s, m;
    logic [4:0] h;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic t, bm, bu, input int s, m, h,
                             input logic es, em, eh, input int md, input logic bmn, bhr);
    vec_t r;
    r.t = t; r.bm = bm; r.bu = bu;
    r.s = 6'(s); r.m = 6'(m); r.h = 5'(h);
    r.exp = {es, em, eh, 2'(md), bmn, bhr};
    return r;
  endfunction

  function automatic logic [6:0] obs();
    return {en_sec, en_min, en_hr, mode, blank_min, blank_hr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic t, input logic bm, input logic bu);
    @(negedge clk);
    tick = t; btn_mode = bm; btn_up = bu;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; tick = 1'b0; btn_mode = 1'b0; btn_up = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int m_sub, m_mode, m_idle, m_s, m_m, m_h, tod;
  logic r_t, r_bm, r_bu, evt, e_s, e_m, e_h;

  initial begin
    // Table: reset cascade, RUN carries, SET_MIN/SET_HR, simultaneous events.
    for (int i = 0; i < 1; i++) vecs.push_back(v(0,0,0, 59,59,23, 0,0,0, 0,0,0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1,0,0, 59,59,23, 0,0,0, 0,0,0));
    vecs.push_back(v(1,0,0, 59,59,23, 1,1,1, 0,0,0));
    vecs.push_back(v(0,0,0, 59,59,23, 0,0,0, 0,0,0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1,0,0, 59,12,5, 0,0,0, 0,0,0));
    vecs.push_back(v(1,0,0, 59,12,5, 1,1,0, 0,0,0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1,0,0, 30,12,5, 0,0,0, 0,0,0));
    vecs.push_back(v(1,0,0, 30,12,5, 1,0,0, 0,0,0));
    vecs.push_back(v(0,1,0, 30,12,5, 0,0,0, 0,0,0));
    vecs.push_back(v(0,0,1, 30,12,5, 0,1,0, 1,0,0));
    vecs.push_back(v(1,0,1, 30,12,5, 0,1,0, 1,0,0));
    vecs.push_back(v(1,0,1, 30,12,5, 0,1,0, 1,0,0));
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        vecs.push_back(v(1,0,0, 30,12,5, 0,0,0, 1,0,0));
        vecs.push_back(v(1,0,0, 30,12,5, 0,0,0, 1,0,0));
      end
      vecs.push_back(v(1,0,0, 30,12,5, 0,0,0, 1,1,0));
      vecs.push_back(v(1,0,0, 30,12,5, 0,0,0, 1,1,0));
    end
    vecs.push_back(v(0,1,0, 30,59,5, 0,0,0, 1,0,0));
    vecs.push_back(v(0,0,1, 30,59,5, 0,0,1, 2,0,0));
    vecs.push_back(v(0,1,0, 30,59,5, 0,0,0, 2,0,0));
    vecs.push_back(v(0,0,0, 30,59,5, 0,0,0, 0,0,0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1,0,0, 59,59,23, 0,0,0, 0,0,0));
    vecs.push_back(v(1,1,0, 59,59,23, 1,1,1, 0,0,0));
    vecs.push_back(v(0,1,1, 59,59,23, 0,1,0, 1,0,0));
    vecs.push_back(v(0,1,0, 59,59,23, 0,0,0, 2,0,0));
    vecs.push_back(v(0,0,0, 59,59,23, 0,0,0, 0,0,0));

    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 32'(obs()), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      sec = vecs[i].s; min = vecs[i].m; hr = vecs[i].h;
      tick = vecs[i].t; btn_mode = vecs[i].bm; btn_up = vecs[i].bu;
      #1;
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
    end

    // Timeout after ten idle seconds in SET_MIN.
    sec = 6'd30; min = 6'd12; hr = 5'd5;
    do_reset();
    drive(0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      drive(1, 0, 0);
      if (i == 39) chk("timeout_before", 32'(mode), 32'd1);
    end
    drive(0, 0, 0);
    chk("timeout_after", 32'(mode), 32'd0);

    // btn_up on the timeout boundary wins and restarts the idle count.
    do_reset();
    drive(0, 1, 0);
    for (int i = 0; i < 39; i++) drive(1, 0, 0);
    drive(1, 0, 1);
    chk("timeout_btn_up_en", 32'({en_sec, en_min, en_hr}), 32'(3'b010));
    for (int i = 0; i < 36; i++) drive(1, 0, 0);
    drive(0, 0, 0);
    chk("idle_cleared_hold", 32'(mode), 32'd1);
    for (int i = 0; i < 4; i++) drive(1, 0, 0);
    drive(0, 0, 0);
    chk("idle_cleared_expire", 32'(mode), 32'd0);

    // btn_mode on the timeout boundary advances SET_MIN to SET_HR.
    do_reset();
    drive(0, 1, 0);
    for (int i = 0; i < 39; i++) drive(1, 0, 0);
    drive(1, 1, 0);
    drive(0, 0, 0);
    chk("timeout_btn_mode", 32'(mode), 32'd2);

    // Asynchronous reset mid-SET_HR while blinking.
    do_reset();
    drive(0, 1, 0);
    drive(0, 1, 0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(0, 0, 0);
    chk("set_hr_blink", 32'({mode, blank_hr}), 32'({2'd2, 1'b1}));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", 32'(obs()), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized run against the reference model.
    do_reset();
    m_sub = 0; m_mode = 0; m_idle = 0;
    tod = 86400 - 50;
    for (int c = 0; c < 4000; c++) begin
      m_h = tod / 3600; m_m = (tod / 60) % 60; m_s = tod % 60;
      r_t = ($urandom_range(1, 0) == 1);
      if ((c / 500) % 2 == 0) begin
        r_bm = ($urandom_range(19, 0) == 0);
        r_bu = ($urandom_range(4, 0) == 0);
      end else begin
        r_bm = ($urandom_range(299, 0) == 0);
        r_bu = ($urandom_range(399, 0) == 0);
      end
      @(negedge clk);
      sec = 6'(m_s); min = 6'(m_m); hr = 5'(m_h);
      tick = r_t; btn_mode = r_bm; btn_up = r_bu;
      #1;
      evt = r_t && (m_sub == SUBTICKS - 1);
      e_s = 1'b0; e_m = 1'b0; e_h = 1'b0;
      if (m_mode == 0) begin
        e_s = evt;
        e_m = evt && (tod % 60 == 59);
        e_h = evt && (tod % 3600 == 3599);
      end else if (m_mode == 1) begin
        e_m = r_bu;
      end else begin
        e_h = r_bu;
      end
      chk($sformatf("rand%0d", c), 32'(obs()),
          32'({e_s, e_m, e_h, 2'(m_mode),
               (m_mode == 1) && (m_sub >= SUBTICKS / 2),
               (m_mode == 2) && (m_sub >= SUBTICKS / 2)}));
      if (m_mode == 0 && e_s) tod = (tod + 1) % 86400;
      if (m_mode == 1 && r_bu) tod = m_h * 3600 + ((m_m + 1) % 60) * 60 + m_s;
      if (m_mode == 2 && r_bu) tod = ((m_h + 1) % 24) * 3600 + m_m * 60 + m_s;
      if (r_bm) begin
        m_mode = (m_mode + 1) % 3;
        m_idle = 0;
      end else if (m_mode != 0) begin
        if (r_bu) m_idle = 0;
        else if (evt) begin
          m_idle++;
          if (m_idle == TIMEOUT_S) begin
            m_mode = 0;
            m_idle = 0;
          end
        end
      end
      if (r_t) m_sub = (m_sub + 1) % SUBTICKS;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
